// File: rtl/multicycle_main_control.sv
// Multi-cycle RV32I main control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with a memory req/ready
// handshake and wait-state timeout. Define ILLEGAL_TRAP_EN to trap unsupported opcodes to HALT.
module multicycle_main_control #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       regwrite,
    output logic [2:0] immsel,
    output logic [1:0] aluop,
    output logic       alusrc,
    output logic [1:0] alua_sel,
    output logic       memread,
    output logic       memwrite,
    output logic [1:0] memtoreg,
    output logic [2:0] state_o,
    output logic       bus_err,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic [6:0]       opcode_q, opcode_d;
    logic [2:0]       func3_q, func3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;

    // func3 is consumed by the datapath; the latched copy has no fanout here.
    logic unused_func3;
    assign unused_func3 = ^func3_q;

    // In DECODE the IR is fresh and not yet latched, so decode straight from the input.
    logic [6:0] op;
    assign op = (state_q == S_DECODE) ? opcode : opcode_q;

    logic       is_legal, is_ld, is_st, is_br, is_jal, is_jalr;
    logic [2:0] imm_t;
    logic [1:0] aluop_t, alua_t;
    logic       alusrc_t;

    always_comb begin
        is_legal = 1'b1;
        is_ld    = 1'b0;
        is_st    = 1'b0;
        is_br    = 1'b0;
        is_jal   = 1'b0;
        is_jalr  = 1'b0;
        imm_t    = 3'b000;
        aluop_t  = 2'b00;
        alua_t   = 2'b00;
        alusrc_t = 1'b0;
        case (op)
            OP_R:     aluop_t = 2'b10;
            OP_I:     begin aluop_t = 2'b11; alusrc_t = 1'b1; end
            OP_LOAD:  begin is_ld = 1'b1; alusrc_t = 1'b1; end
            OP_STORE: begin is_st = 1'b1; imm_t = 3'b001; alusrc_t = 1'b1; end
            OP_BR:    begin is_br = 1'b1; imm_t = 3'b010; aluop_t = 2'b01; end
            OP_JAL:   begin is_jal = 1'b1; imm_t = 3'b011; alusrc_t = 1'b1; alua_t = 2'b01; end
            OP_JALR:  begin is_jalr = 1'b1; alusrc_t = 1'b1; end
            OP_LUI:   begin imm_t = 3'b100; alusrc_t = 1'b1; alua_t = 2'b10; end
            OP_AUIPC: begin imm_t = 3'b100; alusrc_t = 1'b1; alua_t = 2'b01; end
            default:  is_legal = 1'b0;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        func3_d   = func3_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    if (state_q == S_FETCH) state_d = S_DECODE;
                    else if (is_st)         state_d = S_FETCH;
                    else                    state_d = S_WB;
                end else if (cnt_q == TMO) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                opcode_d = opcode;
                func3_d  = func3;
                if (is_legal) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                if (is_br)               state_d = S_FETCH;
                else if (is_ld || is_st) state_d = S_MEM;
                else                     state_d = S_WB;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // Each memory request gets its own full wait budget.
        if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
            cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            opcode_q  <= '0;
            func3_q   <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            func3_q   <= func3_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // IR/PC write strobes complete the fetch handshake; immsel is held through WB so the
    // immediate stays valid for the EXEC-stage PC targets.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src   = 2'b00;
        regwrite = 1'b0;
        immsel   = 3'b000;
        aluop    = 2'b00;
        alusrc   = 1'b0;
        alua_sel = 2'b00;
        memread  = 1'b0;
        memwrite = 1'b0;
        memtoreg = 2'b00;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: immsel = imm_t;
                S_EXEC: begin
                    immsel   = imm_t;
                    aluop    = aluop_t;
                    alusrc   = alusrc_t;
                    alua_sel = alua_t;
                    if (is_br) begin
                        pc_write = branch_taken;
                        pc_src   = 2'b01;
                    end else if (is_jal) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b01;
                    end else if (is_jalr) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                    end
                end
                S_MEM: begin
                    immsel   = imm_t;
                    dmem_req = 1'b1;
                    memread  = is_ld;
                    memwrite = is_st;
                end
                S_WB: begin
                    immsel   = imm_t;
                    regwrite = 1'b1;
                    if (is_ld)                memtoreg = 2'b01;
                    else if (is_jal || is_jalr) memtoreg = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign state_o = rst_n ? state_q : 3'd0;
    assign bus_err = rst_n & bus_err_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal = rst_n & illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: per-cycle expected output vectors are queued
// as stimulus is driven and compared against the DUT mid-cycle.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       imem_req, dmem_req, ir_write, pc_write, regwrite, alusrc;
    logic       memread, memwrite, bus_err, illegal;
    logic [1:0] pc_src, aluop, alua_sel, memtoreg;
    logic [2:0] immsel, state_o;

    multicycle_main_control #(.CNT_W(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .regwrite(regwrite), .immsel(immsel), .aluop(aluop),
        .alusrc(alusrc), .alua_sel(alua_sel), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .state_o(state_o), .bus_err(bus_err), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       imem, dmem, irw, pcw;
        logic [1:0] pcsrc;
        logic       rw;
        logic [2:0] imm;
        logic [1:0] aluop;
        logic       alusrc;
        logic [1:0] alua;
        logic       mr, mw;
        logic [1:0] m2r;
        logic       berr, ill;
    } exp_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] imm;
        logic [1:0] aluop;
        logic       alusrc;
        logic [1:0] alua;
        logic       pcw;
        logic [1:0] pcsrc;
        logic [1:0] m2r;
    } row_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic exp_t obs();
        exp_t o;
        o.st = state_o; o.imem = imem_req; o.dmem = dmem_req; o.irw = ir_write;
        o.pcw = pc_write; o.pcsrc = pc_src; o.rw = regwrite; o.imm = immsel;
        o.aluop = aluop; o.alusrc = alusrc; o.alua = alua_sel; o.mr = memread;
        o.mw = memwrite; o.m2r = memtoreg; o.berr = bus_err; o.ill = illegal;
        return o;
    endfunction

    function automatic exp_t z(input logic [2:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic exp_t fetch_e(input logic rdy);
        exp_t e;
        e = z(3'd0);
        e.imem = 1'b1; e.irw = rdy; e.pcw = rdy;
        return e;
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
        advance();
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [6:0] op, input logic rdy, input logic bt, input exp_t e);
        opcode = op; mem_ready = rdy; branch_taken = bt; func3 = 3'($urandom);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic test_reset();
        exp_t got, ex;
        rst_n = 1'b0;
        advance(); advance();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rst_n = !(i >= 2 && i < 5);
            if (rst_n) drive(7'b0110011, 1'b0, 1'b0, fetch_e(1'b0));
            else       drive(7'b0110011, 1'b1, 1'b0, z(3'd0));
            got = obs(); ex = sb.pop_front(); n_tests++;
            if (got !== ex) begin
                n_fail++; $display("FAIL reset cyc%0d got=%h exp=%h", i, got, ex);
            end
            advance();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_wait();
        exp_t got, ex, e;
        logic rq[$];
        do_reset();
        sb.push_back(fetch_e(1'b1)); rq.push_back(1'b1);
        sb.push_back(z(3'd1)); rq.push_back(1'b0);
        e = z(3'd2); e.alusrc = 1'b1; sb.push_back(e); rq.push_back(1'b0);
        e = z(3'd3); e.dmem = 1'b1; e.mr = 1'b1;
        for (int k = 0; k < 4; k++) begin sb.push_back(e); rq.push_back(k == 3); end
        e = z(3'd4); e.rw = 1'b1; e.m2r = 2'b01; sb.push_back(e); rq.push_back(1'b0);
        sb.push_back(fetch_e(1'b0)); rq.push_back(1'b0);
        for (int i = 0; i < 9; i++) begin
            ex = sb.pop_front();
            drive(7'b0000011, rq[i], 1'b0, ex);
            got = obs(); ex = sb.pop_back(); n_tests++;
            if (got !== ex) begin
                n_fail++; $display("FAIL load_wait cyc%0d got=%h exp=%h", i, got, ex);
            end
            advance();
        end
    endtask

    task automatic test_branch();
        exp_t got, ex, e;
        exp_t seq[4];
        for (int bt = 0; bt < 2; bt++) begin
            do_reset();
            seq[0] = fetch_e(1'b1);
            seq[1] = z(3'd1); seq[1].imm = 3'b010;
            e = z(3'd2); e.imm = 3'b010; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcw = bt[0];
            seq[2] = e;
            seq[3] = fetch_e(1'b0);
            for (int i = 0; i < 4; i++) begin
                drive(7'b1100011, (i == 0), bt[0], seq[i]);
                got = obs(); ex = sb.pop_front(); n_tests++;
                if (got !== ex) begin
                    n_fail++; $display("FAIL branch bt%0d cyc%0d got=%h exp=%h", bt, i, got, ex);
                end
                advance();
            end
        end
    endtask

    task automatic test_wb_types();
        exp_t got, ex, e;
        exp_t seq[5];
        row_t rows[6];
        rows[0] = '{7'b0110011, 3'b000, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
        rows[1] = '{7'b0010011, 3'b000, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00};
        rows[2] = '{7'b0110111, 3'b100, 2'b00, 1'b1, 2'b10, 1'b0, 2'b00, 2'b00};
        rows[3] = '{7'b0010111, 3'b100, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00};
        rows[4] = '{7'b1101111, 3'b011, 2'b00, 1'b1, 2'b01, 1'b1, 2'b01, 2'b10};
        rows[5] = '{7'b1100111, 3'b000, 2'b00, 1'b1, 2'b00, 1'b1, 2'b10, 2'b10};
        for (int r = 0; r < 6; r++) begin
            do_reset();
            seq[0] = fetch_e(1'b1);
            seq[1] = z(3'd1); seq[1].imm = rows[r].imm;
            e = z(3'd2); e.imm = rows[r].imm; e.aluop = rows[r].aluop; e.alusrc = rows[r].alusrc;
            e.alua = rows[r].alua; e.pcw = rows[r].pcw; e.pcsrc = rows[r].pcsrc;
            seq[2] = e;
            e = z(3'd4); e.imm = rows[r].imm; e.rw = 1'b1; e.m2r = rows[r].m2r;
            seq[3] = e;
            seq[4] = fetch_e(1'b0);
            for (int i = 0; i < 5; i++) begin
                drive(rows[r].op, (i == 0), 1'b0, seq[i]);
                got = obs(); ex = sb.pop_front(); n_tests++;
                if (got !== ex) begin
                    n_fail++; $display("FAIL wb_type op%b cyc%0d got=%h exp=%h", rows[r].op, i, got, ex);
                end
                advance();
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, ex, e;
        exp_t seq[9];
        logic [6:0] ops[9];
        do_reset();
        seq[0] = fetch_e(1'b1);
        seq[1] = z(3'd1); seq[1].imm = 3'b001;
        e = z(3'd2); e.imm = 3'b001; e.alusrc = 1'b1; seq[2] = e;
        e = z(3'd3); e.imm = 3'b001; e.dmem = 1'b1; e.mw = 1'b1; seq[3] = e;
        seq[4] = fetch_e(1'b1);
        seq[5] = z(3'd1);
        e = z(3'd2); e.aluop = 2'b10; seq[6] = e;
        e = z(3'd4); e.rw = 1'b1; seq[7] = e;
        seq[8] = fetch_e(1'b0);
        for (int i = 0; i < 9; i++) ops[i] = (i < 4) ? 7'b0100011 : 7'b0110011;
        for (int i = 0; i < 9; i++) begin
            drive(ops[i], (i == 0 || i == 3 || i == 4), 1'b0, seq[i]);
            got = obs(); ex = sb.pop_front(); n_tests++;
            if (got !== ex) begin
                n_fail++; $display("FAIL back_to_back cyc%0d got=%h exp=%h", i, got, ex);
            end
            advance();
        end
    endtask

    task automatic test_timeout();
        exp_t got, ex, e;
        // Fetch never answered: 16 request cycles, then HALT with bus_err.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            e = fetch_e(1'b0);
            if (i >= 16) begin e = z(3'd5); e.berr = 1'b1; end
            drive(7'b0110011, (i >= 16), 1'b0, e);
            got = obs(); ex = sb.pop_front(); n_tests++;
            if (got !== ex) begin
                n_fail++; $display("FAIL fetch_timeout cyc%0d got=%h exp=%h", i, got, ex);
            end
            advance();
        end
        // Ready on the last allowed cycle is accepted.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            e = (i < 16) ? fetch_e(i == 15) : z(3'd1);
            drive(7'b0110011, (i == 15), 1'b0, e);
            got = obs(); ex = sb.pop_front(); n_tests++;
            if (got !== ex) begin
                n_fail++; $display("FAIL fetch_late_ready cyc%0d got=%h exp=%h", i, got, ex);
            end
            advance();
        end
        // Data access never answered.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i == 0)      e = fetch_e(1'b1);
            else if (i == 1) e = z(3'd1);
            else if (i == 2) begin e = z(3'd2); e.alusrc = 1'b1; end
            else if (i < 19) begin e = z(3'd3); e.dmem = 1'b1; e.mr = 1'b1; end
            else             begin e = z(3'd5); e.berr = 1'b1; end
            drive(7'b0000011, (i == 0), 1'b0, e);
            got = obs(); ex = sb.pop_front(); n_tests++;
            if (got !== ex) begin
                n_fail++; $display("FAIL mem_timeout cyc%0d got=%h exp=%h", i, got, ex);
            end
            advance();
        end
    endtask

    task automatic test_illegal();
        exp_t got, ex, e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 0)      e = fetch_e(1'b1);
            else if (i == 1) e = z(3'd1);
            else begin
`ifdef ILLEGAL_TRAP_EN
                e = z(3'd5); e.ill = 1'b1;
`else
                e = fetch_e(1'b0);
`endif
            end
            drive(7'b1111111, (i == 0), 1'b0, e);
            got = obs(); ex = sb.pop_front(); n_tests++;
            if (got !== ex) begin
                n_fail++; $display("FAIL illegal cyc%0d got=%h exp=%h", i, got, ex);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_load_wait();
        test_branch();
        test_wb_types();
        test_back_to_back();
        test_timeout();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, tests=%0d", n_tests);
        $fatal(1);
    end

endmodule
